// File: rtl/board_ctl_if.sv
// -----------------------------------------------------------------------------
// board_ctl_if
// Bundles the falling-piece controller <-> board controller signals.
//   master (piece controller): drives pose, lock_en, rd_row; reads the rest.
//   slave  (board_ctl)       : reads pose, lock_en, rd_row; drives the rest.
// Pose      : xpos[3:0], ypos[4:0], block[4:0], rot[1:0]
// Commit    : lock_en (one-cycle request)
// Squares   : sq_N_col[3:0], sq_N_row[4:0] for N = 1..4 (combinational)
// Status    : collision, busy, lines_cleared[15:0], game_over
// Render    : rd_row[4:0] -> rd_data[9:0] (one-cycle latency)
// Optional  : flash_row[4:0] when ROW_FLASH_EN is defined
// -----------------------------------------------------------------------------
interface board_ctl_if;
   logic [3:0]  xpos;
   logic [4:0]  ypos;
   logic [4:0]  block;
   logic [1:0]  rot;
   logic        lock_en;
   logic [4:0]  rd_row;

   logic [3:0]  sq_1_col, sq_2_col, sq_3_col, sq_4_col;
   logic [4:0]  sq_1_row, sq_2_row, sq_3_row, sq_4_row;
   logic        collision;
   logic [9:0]  rd_data;
   logic        busy;
   logic [15:0] lines_cleared;
   logic        game_over;
`ifdef ROW_FLASH_EN
   logic [4:0]  flash_row;
`endif

   modport master (
      output xpos, ypos, block, rot, lock_en, rd_row,
      input  sq_1_col, sq_2_col, sq_3_col, sq_4_col,
      input  sq_1_row, sq_2_row, sq_3_row, sq_4_row,
      input  collision, rd_data, busy, lines_cleared, game_over
`ifdef ROW_FLASH_EN
      , input flash_row
`endif
   );

   modport slave (
      input  xpos, ypos, block, rot, lock_en, rd_row,
      output sq_1_col, sq_2_col, sq_3_col, sq_4_col,
      output sq_1_row, sq_2_row, sq_3_row, sq_4_row,
      output collision, rd_data, busy, lines_cleared, game_over
`ifdef ROW_FLASH_EN
      , output flash_row
`endif
   );
endinterface

// File: rtl/board_ctl.sv
// -----------------------------------------------------------------------------
// board_ctl
// Playfield occupancy grid (ROWS x 10, row 0 at top) for a falling-block game.
// Turns the piece pose into four square coordinates, reports a registered
// downward-collision flag, commits the piece on lock_en and then runs a
// sequential full-row clear/shift pass. A registered row port feeds the
// renderer.
// Ports:
//   pclk : clock
//   rst  : synchronous active-high reset
//   bus  : board_ctl_if.slave (pose, lock_en, rd_row in; squares, collision,
//          rd_data, busy, lines_cleared, game_over out)
// Build option: define ROW_FLASH_EN to insert a FLASH hold state of
//   FLASH_CYCLES cycles before each row shift and drive bus.flash_row.
// -----------------------------------------------------------------------------
module board_ctl #(
   parameter int ROWS = 22
`ifdef ROW_FLASH_EN
   , parameter int FLASH_CYCLES = 4096
`endif
) (
   input logic        pclk,
   input logic        rst,
   board_ctl_if.slave bus
);
   localparam int COLS = 10;

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] WRITE = 3'd1;
   localparam logic [2:0] SCAN  = 3'd2;
   localparam logic [2:0] SHIFT = 3'd3;
`ifdef ROW_FLASH_EN
   localparam logic [2:0] FLASH = 3'd4;
   localparam int         FW    = $clog2(FLASH_CYCLES + 1);
   logic [FW-1:0]         flash_cnt;
`endif

   logic [9:0]        grid [ROWS];
   logic [2:0]        state;
   logic [4:0]        scan_row;
   logic [4:0]        shift_row;
   logic [15:0]       lines;
   logic              game_over_q;
   logic              collision_q;
   logic [9:0]        rd_data_q;

   logic signed [2:0] base_dx [4];
   logic signed [2:0] base_dy [4];
   logic signed [2:0] dx [4];
   logic signed [2:0] dy [4];
   logic [3:0]        col [4];
   logic [4:0]        row [4];
   logic              in_range [4];
   logic [1:0]        eff_rot;
   logic              hit;

   // Rotation-0 shape table.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      base_dx = '{3'sd0, 3'sd0, 3'sd0, 3'sd0};
      base_dy = '{3'sd0, 3'sd0, 3'sd0, 3'sd0};
      case (bus.block)
         5'b10000: base_dx = '{-3'sd1, 3'sd0, 3'sd1, 3'sd2};                  // I
         5'b10001: begin                                                      // O
            base_dx = '{3'sd0, 3'sd1, 3'sd0, 3'sd1};
            base_dy = '{3'sd0, 3'sd0, 3'sd1, 3'sd1};
         end
         5'b10010: begin                                                      // T
            base_dx = '{-3'sd1, 3'sd0, 3'sd1, 3'sd0};
            base_dy = '{3'sd0, 3'sd0, 3'sd0, 3'sd1};
         end
         5'b10011: begin                                                      // S
            base_dx = '{3'sd0, 3'sd1, -3'sd1, 3'sd0};
            base_dy = '{3'sd0, 3'sd0, 3'sd1, 3'sd1};
         end
         5'b10100: begin                                                      // Z
            base_dx = '{-3'sd1, 3'sd0, 3'sd0, 3'sd1};
            base_dy = '{3'sd0, 3'sd0, 3'sd1, 3'sd1};
         end
         5'b10101: begin                                                      // J
            base_dx = '{-3'sd1, 3'sd0, 3'sd1, 3'sd1};
            base_dy = '{3'sd0, 3'sd0, 3'sd0, 3'sd1};
         end
         5'b10110: begin                                                      // L
            base_dx = '{-3'sd1, 3'sd0, 3'sd1, -3'sd1};
            base_dy = '{3'sd0, 3'sd0, 3'sd0, 3'sd1};
         end
         default: ;
      endcase
   end

   // Clockwise rotation (dx,dy) -> (-dy,dx) applied rot times; O is symmetric.
   // Coordinates wrap modulo the port widths (16 columns, 32 rows).
   assign eff_rot = (bus.block == 5'b10001) ? 2'd0 : bus.rot;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         case (eff_rot)
            2'd0:    begin dx[i] = base_dx[i];  dy[i] = base_dy[i];  end
            2'd1:    begin dx[i] = -base_dy[i]; dy[i] = base_dx[i];  end
            2'd2:    begin dx[i] = -base_dx[i]; dy[i] = -base_dy[i]; end
            default: begin dx[i] = base_dy[i];  dy[i] = -base_dx[i]; end
         endcase
         col[i]      = bus.xpos + {dx[i][2], dx[i]};
         row[i]      = bus.ypos + {{2{dy[i][2]}}, dy[i]};
         in_range[i] = (int'(col[i]) < COLS) && (int'(row[i]) < ROWS);
      end
   end

   // Any square resting on the floor or on an occupied cell directly below.
   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (int'(row[i]) + 1 >= ROWS)
            hit = 1'b1;
         else if ((int'(col[i]) < COLS) && grid[row[i] + 5'd1][col[i]])
            hit = 1'b1;
      end
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         // NOTE: the grid must read back empty after reset, so this memory is
         //       deliberately reset (it stays in flops, not a RAM macro).
         for (int r = 0; r < ROWS; r++) grid[r] <= '0;
         state       <= IDLE;
         scan_row    <= '0;
         shift_row   <= '0;
         lines       <= '0;
         game_over_q <= 1'b0;
         collision_q <= 1'b0;
         rd_data_q   <= '0;
`ifdef ROW_FLASH_EN
         flash_cnt   <= '0;
`endif
      end else begin
         // NOTE: sequential state uses non-blocking assignments only, so every
         //       read below sees the pre-edge grid.
         collision_q <= (state != IDLE) ? 1'b0 : hit;
         rd_data_q   <= (int'(bus.rd_row) < ROWS) ? grid[bus.rd_row] : '0;

         case (state)
            IDLE: if (bus.lock_en) state <= WRITE;

            WRITE: begin
               for (int i = 0; i < 4; i++) begin
                  if (in_range[i]) begin
                     grid[row[i]][col[i]] <= 1'b1;
                     if (row[i] == 5'd0) game_over_q <= 1'b1;
                  end
               end
               scan_row <= 5'(ROWS - 1);
               state    <= SCAN;
            end

            SCAN: begin
               if (grid[scan_row] == 10'h3FF) begin
                  shift_row <= scan_row;
`ifdef ROW_FLASH_EN
                  flash_cnt <= '0;
                  state     <= FLASH;
`else
                  state     <= SHIFT;
`endif
               end else if (scan_row == 5'd0) begin
                  state <= IDLE;
               end else begin
                  scan_row <= scan_row - 5'd1;
               end
            end

`ifdef ROW_FLASH_EN
            FLASH: begin
               if (flash_cnt == FW'(FLASH_CYCLES - 1)) state <= SHIFT;
               else flash_cnt <= flash_cnt + 1'b1;
            end
`endif

            // scan_row is left alone so the row pulled down is checked again.
            SHIFT: begin
               if (shift_row == 5'd0) begin
                  grid[0] <= '0;
                  lines   <= lines + 16'd1;
                  state   <= SCAN;
               end else begin
                  grid[shift_row] <= grid[shift_row - 5'd1];
                  shift_row       <= shift_row - 5'd1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   assign bus.sq_1_col      = col[0];
   assign bus.sq_2_col      = col[1];
   assign bus.sq_3_col      = col[2];
   assign bus.sq_4_col      = col[3];
   assign bus.sq_1_row      = row[0];
   assign bus.sq_2_row      = row[1];
   assign bus.sq_3_row      = row[2];
   assign bus.sq_4_row      = row[3];
   assign bus.collision     = collision_q;
   assign bus.rd_data       = rd_data_q;
   assign bus.busy          = (state != IDLE);
   assign bus.lines_cleared = lines;
   assign bus.game_over     = game_over_q;
`ifdef ROW_FLASH_EN
   assign bus.flash_row     = (state == FLASH) ? shift_row : 5'd31;
`endif

endmodule

// File: tb/tb_board_ctl.sv
// -----------------------------------------------------------------------------
// tb_board_ctl
// Directed bench for board_ctl. Expected values are pushed onto a scoreboard
// queue when stimulus is applied and popped when the matching DUT output is
// sampled (#1 after the rising edge).
// -----------------------------------------------------------------------------
module tb_board_ctl;
   localparam logic [4:0] BLK_I   = 5'b10000;
   localparam logic [4:0] BLK_O   = 5'b10001;
   localparam logic [4:0] BLK_T   = 5'b10010;
   localparam logic [4:0] BLK_S   = 5'b10011;
   localparam logic [4:0] BLK_Z   = 5'b10100;
   localparam logic [4:0] BLK_L   = 5'b10110;
   localparam logic [4:0] BLK_BAD = 5'b00000;

   logic pclk = 1'b0;
   logic rst  = 1'b1;

   board_ctl_if bus ();
   board_ctl #(.ROWS(22)) dut (.pclk(pclk), .rst(rst), .bus(bus));

   always #5 pclk = ~pclk;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;

   task automatic step(input int n);
      repeat (n) @(posedge pclk);
      #1;
   endtask

   task automatic expect_v(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      exp_q.push_back(e);
   endtask

   task automatic compare_v(input logic [31:0] obs);
      exp_t e;
      vectors++;
      if (exp_q.size() == 0) begin
         miscompares++;
         $error("FAIL scoreboard_empty: observed %0h required <none>", obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e.val) else begin
            miscompares++;
            $error("FAIL %s: observed %0h required %0h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic set_pose(input logic [3:0] x, input logic [4:0] y,
                           input logic [4:0] b, input logic [1:0] r);
      bus.xpos  = x;
      bus.ypos  = y;
      bus.block = b;
      bus.rot   = r;
   endtask

   task automatic chk_sq(input string tag,
                         input logic [3:0] c1, input logic [4:0] r1,
                         input logic [3:0] c2, input logic [4:0] r2,
                         input logic [3:0] c3, input logic [4:0] r3,
                         input logic [3:0] c4, input logic [4:0] r4);
      expect_v({tag, "_c1"}, 32'(c1)); expect_v({tag, "_r1"}, 32'(r1));
      expect_v({tag, "_c2"}, 32'(c2)); expect_v({tag, "_r2"}, 32'(r2));
      expect_v({tag, "_c3"}, 32'(c3)); expect_v({tag, "_r3"}, 32'(r3));
      expect_v({tag, "_c4"}, 32'(c4)); expect_v({tag, "_r4"}, 32'(r4));
      #1;
      compare_v(32'(bus.sq_1_col)); compare_v(32'(bus.sq_1_row));
      compare_v(32'(bus.sq_2_col)); compare_v(32'(bus.sq_2_row));
      compare_v(32'(bus.sq_3_col)); compare_v(32'(bus.sq_3_row));
      compare_v(32'(bus.sq_4_col)); compare_v(32'(bus.sq_4_row));
   endtask

   task automatic read_row(input string tag, input logic [4:0] r, input logic [9:0] v);
      expect_v(tag, 32'(v));
      bus.rd_row = r;
      step(1);
      compare_v(32'(bus.rd_data));
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (bus.busy === 1'b1 && n < 2000) begin
         step(1);
         n++;
      end
      expect_v({tag, "_idle"}, 32'd0);
      compare_v(32'(bus.busy));
   endtask

   task automatic lock(input logic [3:0] x, input logic [4:0] y,
                       input logic [4:0] b, input logic [1:0] r);
      set_pose(x, y, b, r);
      bus.lock_en = 1'b1;
      step(1);
      bus.lock_en = 1'b0;
      step(1);
      wait_idle("lock");
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      bus.lock_en = 1'b0;
      bus.rd_row  = 5'd0;
      step(2);
      rst = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bus.lock_en = 1'b0;
      bus.rd_row  = 5'd0;
      set_pose(4'd0, 5'd0, BLK_BAD, 2'd0);

      // ---- reset state and empty grid ----
      do_reset();
      expect_v("rst_busy", 0);       compare_v(32'(bus.busy));
      expect_v("rst_collision", 0);  compare_v(32'(bus.collision));
      expect_v("rst_game_over", 0);  compare_v(32'(bus.game_over));
      expect_v("rst_lines", 0);      compare_v(32'(bus.lines_cleared));

      set_pose(4'd5, 5'd0, BLK_T, 2'd0);
      chk_sq("t_rot0", 4'd4, 5'd0, 4'd5, 5'd0, 4'd6, 5'd0, 4'd5, 5'd1);
      expect_v("t_top_collision", 0);
      step(1);
      compare_v(32'(bus.collision));
      for (int r = 0; r < 22; r++) read_row("empty_row", 5'(r), 10'h000);

      // ---- shape / rotation / wrap coverage ----
      set_pose(4'd3, 5'd7, BLK_O, 2'd2);
      chk_sq("o_rot2", 4'd3, 5'd7, 4'd4, 5'd7, 4'd3, 5'd8, 4'd4, 5'd8);
      set_pose(4'd5, 5'd10, BLK_L, 2'd2);
      chk_sq("l_rot2", 4'd6, 5'd10, 4'd5, 5'd10, 4'd4, 5'd10, 4'd6, 5'd9);
      set_pose(4'd5, 5'd5, BLK_S, 2'd1);
      chk_sq("s_rot1", 4'd5, 5'd5, 4'd5, 5'd6, 4'd4, 5'd4, 4'd4, 5'd5);
      set_pose(4'd7, 5'd3, BLK_BAD, 2'd3);
      chk_sq("bad_code", 4'd7, 5'd3, 4'd7, 5'd3, 4'd7, 5'd3, 4'd7, 5'd3);
      set_pose(4'd0, 5'd3, BLK_I, 2'd0);
      chk_sq("i_colwrap", 4'd15, 5'd3, 4'd0, 5'd3, 4'd1, 5'd3, 4'd2, 5'd3);
      set_pose(4'd9, 5'd19, BLK_I, 2'd1);
      chk_sq("i_rot1", 4'd9, 5'd18, 4'd9, 5'd19, 4'd9, 5'd20, 4'd9, 5'd21);
      set_pose(4'd0, 5'd0, BLK_Z, 2'd3);
      chk_sq("z_rowwrap", 4'd0, 5'd1, 4'd0, 5'd0, 4'd1, 5'd0, 4'd1, 5'd31);
      expect_v("rowwrap_collision", 1);
      step(1);
      compare_v(32'(bus.collision));

      // ---- floor collision and a lock with no full row ----
      set_pose(4'd4, 5'd21, BLK_I, 2'd0);
      expect_v("floor_collision", 1);
      step(1);
      compare_v(32'(bus.collision));
      expect_v("busy_collision_forced0", 0);
      expect_v("busy_cycles", 23);
      bus.lock_en = 1'b1;
      step(1);
      bus.lock_en = 1'b0;
      n = 0;
      while (bus.busy === 1'b1 && n < 100) begin
         n++;
         if (n == 2) compare_v(32'(bus.collision));
         step(1);
      end
      compare_v(32'(n));
      read_row("floor_row21", 5'd21, 10'h078);
      read_row("floor_row20", 5'd20, 10'h000);
      read_row("rd_row_oob", 5'd25, 10'h000);
      expect_v("floor_lines", 0);  compare_v(32'(bus.lines_cleared));

      // ---- single row clear, lock ignored while busy ----
      do_reset();
      lock(4'd5, 5'd21, BLK_I, 2'd0);
      lock(4'd8, 5'd20, BLK_O, 2'd0);
      read_row("pre_row21", 5'd21, 10'h3F0);
      read_row("pre_row20", 5'd20, 10'h300);
      set_pose(4'd1, 5'd21, BLK_I, 2'd0);
      bus.lock_en = 1'b1;
      step(1);
      bus.lock_en = 1'b0;
      step(3);
      set_pose(4'd0, 5'd5, BLK_O, 2'd0);
      bus.lock_en = 1'b1;
      step(1);
      bus.lock_en = 1'b0;
      wait_idle("clear1");
      read_row("clr1_row21", 5'd21, 10'h300);
      read_row("clr1_row20", 5'd20, 10'h000);
      read_row("clr1_row0", 5'd0, 10'h000);
      read_row("ignored_row5", 5'd5, 10'h000);
      read_row("ignored_row6", 5'd6, 10'h000);
      expect_v("clr1_lines", 1);  compare_v(32'(bus.lines_cleared));

      // ---- two rows cleared by one vertical I ----
      do_reset();
      lock(4'd1, 5'd20, BLK_O, 2'd0);
      lock(4'd3, 5'd20, BLK_O, 2'd0);
      lock(4'd5, 5'd20, BLK_O, 2'd0);
      lock(4'd7, 5'd20, BLK_O, 2'd0);
      lock(4'd9, 5'd19, BLK_I, 2'd1);
      read_row("pre2_row21", 5'd21, 10'h3FE);
      read_row("pre2_row20", 5'd20, 10'h3FE);
      read_row("pre2_row19", 5'd19, 10'h200);
      lock(4'd0, 5'd19, BLK_I, 2'd1);
      read_row("clr2_row21", 5'd21, 10'h201);
      read_row("clr2_row20", 5'd20, 10'h201);
      read_row("clr2_row19", 5'd19, 10'h000);
      read_row("clr2_row18", 5'd18, 10'h000);
      expect_v("clr2_lines", 2);  compare_v(32'(bus.lines_cleared));

      // ---- reset in the middle of a SHIFT pass ----
      lock(4'd1, 5'd20, BLK_O, 2'd0);
      lock(4'd3, 5'd20, BLK_O, 2'd0);
      lock(4'd5, 5'd20, BLK_O, 2'd0);
      read_row("pre3_row21", 5'd21, 10'h27F);
      set_pose(4'd7, 5'd20, BLK_O, 2'd0);
      bus.lock_en = 1'b1;
      step(1);
      bus.lock_en = 1'b0;
      step(6);
      expect_v("mid_shift_busy", 1);   compare_v(32'(bus.busy));
      expect_v("mid_shift_lines", 2);  compare_v(32'(bus.lines_cleared));
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      expect_v("midrst_busy", 0);       compare_v(32'(bus.busy));
      expect_v("midrst_lines", 0);      compare_v(32'(bus.lines_cleared));
      expect_v("midrst_collision", 0);  compare_v(32'(bus.collision));
      expect_v("midrst_rd_data", 0);    compare_v(32'(bus.rd_data));
      read_row("midrst_row21", 5'd21, 10'h000);
      read_row("midrst_row20", 5'd20, 10'h000);
      read_row("midrst_row19", 5'd19, 10'h000);
      read_row("midrst_row0", 5'd0, 10'h000);

      // ---- game_over is sticky until reset ----
      expect_v("go_before", 0);  compare_v(32'(bus.game_over));
      set_pose(4'd5, 5'd0, BLK_T, 2'd0);
      bus.lock_en = 1'b1;
      step(1);
      bus.lock_en = 1'b0;
      expect_v("go_after_write", 1);
      step(1);
      compare_v(32'(bus.game_over));
      wait_idle("go1");
      lock(4'd5, 5'd10, BLK_I, 2'd0);
      expect_v("go_sticky", 1);  compare_v(32'(bus.game_over));
      read_row("go_row0", 5'd0, 10'h070);
      read_row("go_row1", 5'd1, 10'h020);
      read_row("go_row10", 5'd10, 10'h0F0);
      do_reset();
      expect_v("go_cleared", 0);  compare_v(32'(bus.game_over));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
